// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, ID-stage hand-off and EX redirect.
// master = fetch queue side, slave = memory/ID/EX environment side.
interface if_fetch_queue_if;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [31:0] im_dout;
   logic        im_req;
   logic [63:0] im_addr;
   logic [31:0] instruction_IF;
   logic [63:0] pc_IF;
   logic        valid_IF;

   modport master (
      input  stall,
      input  branch_taken,
      input  branch_target,
      input  im_dout,
      output im_req,
      output im_addr,
      output instruction_IF,
      output pc_IF,
      output valid_IF
   );

   modport slave (
      output stall,
      output branch_taken,
      output branch_target,
      output im_dout,
      input  im_req,
      input  im_addr,
      input  instruction_IF,
      input  pc_IF,
      input  valid_IF
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential fetch into a DEPTH-entry {pc, insn} FIFO
// feeding ID, with EX redirect flushing both the queue and the outstanding request.
module if_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP_INSN = 32'h00000013
) (
   input logic              clk,
   input logic              reset,
   if_fetch_queue_if.master bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("if_fetch_queue: DEPTH must be a power of two >= 2");
   end

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic [63:0]   inflight_pc_q, inflight_pc_d;
   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [63:0]   pc_mem_q   [DEPTH];
   logic [31:0]   insn_mem_q [DEPTH];

   logic          flush;
   logic [CW-1:0] occupancy;
   logic          issue;
   logic          push;
   logic          pop;
   logic          head_valid;

   // Counting the in-flight request as occupied guarantees its response always has a slot.
   always_comb begin
      flush      = bus.branch_taken;
      occupancy  = count_q + CW'(inflight_q);
      head_valid = (count_q != '0);
      issue      = reset && !flush && (occupancy < CW'(DEPTH));
      push       = inflight_q && !flush;
      pop        = head_valid && !bus.stall && !flush;
   end

   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      fetch_pc_d    = fetch_pc_q;

      if (issue) begin
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + 64'd4;
      end
      if (push) begin
         tail_d = tail_q + AW'(1);
      end
      if (pop) begin
         head_d = head_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (flush) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         inflight_d = 1'b0;
         fetch_pc_d = {bus.branch_target[63:2], 2'b00};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         fetch_pc_q    <= RESET_PC;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         fetch_pc_q    <= fetch_pc_d;
      end
   end

   // Payload storage carries no reset; count_q alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[tail_q]   <= inflight_pc_q;
         insn_mem_q[tail_q] <= bus.im_dout;
      end
   end

   assign bus.im_req         = issue;
   assign bus.im_addr        = fetch_pc_q;
   assign bus.valid_IF       = head_valid;
   assign bus.instruction_IF = head_valid ? insn_mem_q[head_q] : NOP_INSN;
   assign bus.pc_IF          = head_valid ? pc_mem_q[head_q] : '0;

   a_no_push_when_full : assert property (@(posedge clk) disable iff (!reset)
      push && !pop |-> (count_q < CW'(DEPTH)));
   a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!reset)
      pop |-> head_valid);
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: stimulus pushes expected {pc, cycle} entries,
// a negedge monitor pops and compares each instruction ID accepts.
module tb_if_fetch_queue;
   logic clk = 1'b0;
   logic reset = 1'b0;

   if_fetch_queue_if bus();

   if_fetch_queue #(
      .DEPTH(4),
      .RESET_PC(64'h0),
      .NOP_INSN(32'h00000013)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      int          cyc;
   } exp_t;

   exp_t expq[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   base = 0;
   int   req_cnt = 0;

   function automatic logic [31:0] word(input logic [63:0] a);
      return {8'hC3, a[23:0]} ^ 32'h0055_AA00;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Synchronous-read instruction memory model.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus.im_dout <= bus.im_req ? word(bus.im_addr) : 32'hDEAD_BEEF;
   end

   always @(negedge clk) begin
      if (reset && bus.im_req) req_cnt++;
   end

   // Scoreboard monitor: every instruction ID accepts must match the next expected entry.
   always @(negedge clk) begin
      if (reset && bus.valid_IF && !bus.stall && !bus.branch_taken) begin
         if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_accept: got pc %h expected none (t=%0t)", bus.pc_IF, $time);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("sb_pc", bus.pc_IF, e.pc);
            chk("sb_insn", {32'h0, bus.instruction_IF}, {32'h0, word(e.pc)});
            chk("sb_cycle", 64'(cyc - base), 64'(e.cyc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input int k);
      while (cyc - base < k) step();
   endtask

   task automatic release_rst();
      step();
      reset = 1'b1;
      base = cyc;
      req_cnt = 0;
   endtask

   task automatic expect_pc(input logic [63:0] pc, input int c);
      exp_t e;
      e.pc = pc;
      e.cyc = c;
      expq.push_back(e);
   endtask

   task automatic end_test(input string name);
      reset = 1'b0;
      #1;
      chk(name, 64'(expq.size()), 64'd0);
      expq.delete();
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = '0;
      repeat (2) step();

      // Reset values
      chk("rst_im_req", {63'h0, bus.im_req}, 64'd0);
      chk("rst_im_addr", bus.im_addr, 64'h0);
      chk("rst_valid", {63'h0, bus.valid_IF}, 64'd0);
      chk("rst_insn", {32'h0, bus.instruction_IF}, 64'h13);
      chk("rst_pc", bus.pc_IF, 64'h0);

      // Free-running stream from reset
      release_rst();
      #1;
      chk("t1_req_c0", {63'h0, bus.im_req}, 64'd1);
      chk("t1_addr_c0", bus.im_addr, 64'h0);
      expect_pc(64'h0, 2);
      expect_pc(64'h4, 3);
      expect_pc(64'h8, 4);
      expect_pc(64'hC, 5);
      go(1);
      chk("t1_no_bypass", {63'h0, bus.valid_IF}, 64'd0);
      chk("t1_addr_c1", bus.im_addr, 64'h4);
      go(6);
      end_test("t1_drained");

      // Stall from reset fills the queue, then release streams without a gap
      bus.stall = 1'b1;
      release_rst();
      go(5);
      chk("t2_hold_pc", bus.pc_IF, 64'h0);
      go(10);
      chk("t2_req_count", 64'(req_cnt), 64'd4);
      chk("t2_req_off", {63'h0, bus.im_req}, 64'd0);
      chk("t2_hold_pc_r", bus.pc_IF, 64'h0);
      chk("t2_hold_insn", {32'h0, bus.instruction_IF}, {32'h0, word(64'h0)});
      expect_pc(64'h0, 10);
      expect_pc(64'h4, 11);
      expect_pc(64'h8, 12);
      expect_pc(64'hC, 13);
      expect_pc(64'h10, 14);
      bus.stall = 1'b0;
      go(15);
      end_test("t2_drained");

      // Redirect with two entries queued and one in flight
      bus.stall = 1'b1;
      release_rst();
      go(3);
      chk("t3_queued_pc", bus.pc_IF, 64'h0);
      bus.stall = 1'b0;
      bus.branch_taken = 1'b1;
      bus.branch_target = 64'h100;
      #1;
      chk("t3_req_flush", {63'h0, bus.im_req}, 64'd0);
      expect_pc(64'h100, 6);
      expect_pc(64'h104, 7);
      go(4);
      bus.branch_taken = 1'b0;
      #1;
      chk("t3_valid_t1", {63'h0, bus.valid_IF}, 64'd0);
      chk("t3_req_t1", {63'h0, bus.im_req}, 64'd1);
      chk("t3_addr_t1", bus.im_addr, 64'h100);
      go(5);
      chk("t3_valid_t2", {63'h0, bus.valid_IF}, 64'd0);
      chk("t3_pc_t2", bus.pc_IF, 64'h0);
      go(8);
      end_test("t3_drained");

      // Redirect to unaligned target while full and stalled: flush wins
      bus.stall = 1'b1;
      release_rst();
      go(5);
      chk("t4_full_valid", {63'h0, bus.valid_IF}, 64'd1);
      chk("t4_full_req", {63'h0, bus.im_req}, 64'd0);
      bus.branch_taken = 1'b1;
      bus.branch_target = 64'h102;
      #1;
      chk("t4_req_flush", {63'h0, bus.im_req}, 64'd0);
      expect_pc(64'h100, 8);
      expect_pc(64'h104, 9);
      go(6);
      bus.branch_taken = 1'b0;
      bus.stall = 1'b0;
      #1;
      chk("t4_addr_t1", bus.im_addr, 64'h100);
      chk("t4_req_t1", {63'h0, bus.im_req}, 64'd1);
      chk("t4_valid_t1", {63'h0, bus.valid_IF}, 64'd0);
      go(7);
      chk("t4_valid_t2", {63'h0, bus.valid_IF}, 64'd0);
      go(10);
      end_test("t4_drained");

      // Asynchronous reset mid-cycle with a full queue
      bus.stall = 1'b1;
      release_rst();
      go(6);
      chk("t5_full_valid", {63'h0, bus.valid_IF}, 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_async_valid", {63'h0, bus.valid_IF}, 64'd0);
      chk("t5_async_insn", {32'h0, bus.instruction_IF}, 64'h13);
      chk("t5_async_req", {63'h0, bus.im_req}, 64'd0);
      chk("t5_async_pc", bus.pc_IF, 64'h0);
      chk("t5_async_addr", bus.im_addr, 64'h0);
      bus.stall = 1'b0;
      release_rst();
      #1;
      chk("t5_restart_addr", bus.im_addr, 64'h0);
      chk("t5_restart_req", {63'h0, bus.im_req}, 64'd1);
      expect_pc(64'h0, 2);
      expect_pc(64'h4, 3);
      go(4);
      end_test("t5_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
